// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and sizing helpers for the radix-4 Booth multiplier
// Contents: FSM state encoding, Booth digit codes, W2/N/CW sizing functions,
//           and the digit decoder for a {L[1],L[0],e} window.
package booth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      DIG_ZERO = 3'd0,
      DIG_PM   = 3'd1,
      DIG_P2M  = 3'd2,
      DIG_NM   = 3'd3,
      DIG_N2M  = 3'd4
   } digit_e;

   // Extended operand width: two guard bits so unsigned operands stay positive.
   function automatic int booth_w2(input int width);
      return width + 2;
   endfunction

   // Iteration count: two multiplier bits retired per iteration.
   function automatic int booth_n(input int width);
      return (width + 2) / 2;
   endfunction

   // Counter width able to hold 0..N.
   function automatic int booth_cw(input int width);
      return $clog2(booth_n(width) + 1);
   endfunction

   function automatic digit_e booth_decode(input logic [2:0] win);
      case (win)
         3'b000, 3'b111: return DIG_ZERO;
         3'b001, 3'b010: return DIG_PM;
         3'b011:         return DIG_P2M;
         3'b100:         return DIG_N2M;
         default:        return DIG_NM;   // 101, 110
      endcase
   endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// rtl/booth_r4_encoder.sv - combinational radix-4 Booth addend selector
// Ports:
//   window_i  3-bit digit window {L[1],L[0],e}
//   m_i       multiplicand, WIDTH+3 bits (already extended)
//   addend_o  selected addend 0, +M, +2M, -M or -2M, WIDTH+3 bits, modulo 2^(WIDTH+3)
module booth_r4_encoder
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       window_i,
   input  logic [WIDTH+2:0] m_i,
   output logic [WIDTH+2:0] addend_o
);

   digit_e digit;

   always_comb begin
      digit    = booth_decode(window_i);
      addend_o = '0;
      case (digit)
         DIG_PM:  addend_o = m_i;
         DIG_P2M: addend_o = m_i << 1;
         DIG_NM:  addend_o = -m_i;
         DIG_N2M: addend_o = -(m_i << 1);
         default: addend_o = '0;
      endcase
   end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// rtl/booth_radix4_multiplier.sv - iterative radix-4 Booth multiplier, signed/unsigned, start/done handshake
// Ports:
//   CLK, RST     clock (rising edge) and synchronous active-high reset
//   Start_Sig    request, sampled only in IDLE
//   Signed_Mode  1 = two's-complement operands, 0 = unsigned (latched at accept)
//   A, B         multiplicand / multiplier (latched at accept)
//   Busy         high in CALC and DONE
//   Done_Sig     one-cycle completion pulse
//   Product      2*WIDTH result, held until the next completion
//   SQ_p         debug view of the working register {H,L,e}
module booth_radix4_multiplier
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 Start_Sig,
   input  logic                 Signed_Mode,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 Busy,
   output logic                 Done_Sig,
   output logic [2*WIDTH-1:0]   Product,
   output logic [2*WIDTH+4:0]   SQ_p
);

   localparam int W2 = booth_w2(WIDTH);
   localparam int N  = booth_n(WIDTH);
   localparam int CW = booth_cw(WIDTH);
   localparam int HW = W2 + 1;
   localparam int RW = HW + W2 + 1;

   if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_radix4_multiplier: WIDTH must be even and >= 4");
   end

   state_e               state_q;
   logic [CW-1:0]        cnt_q;
   logic [HW-1:0]        m_q;
   logic [HW-1:0]        h_q;
   logic [W2-1:0]        l_q;
   logic                 e_q;
   logic [2*WIDTH-1:0]   product_q;
   logic                 done_q;
   logic                 busy_q;

   logic [HW-1:0]        a_ext;
   logic [W2-1:0]        b_ext;
   logic [HW-1:0]        addend;
   logic [HW-1:0]        h_sum;
   logic [RW-1:0]        shifted;
   logic [HW-1:0]        h_d;
   logic [W2-1:0]        l_d;
   logic                 e_d;
   logic [2*WIDTH-1:0]   product_d;
   logic                 last_iter;

   booth_r4_encoder #(.WIDTH(WIDTH)) u_enc (
      .window_i (l_q[1:0] == 2'b00 ? {2'b00, e_q} : {l_q[1:0], e_q}),
      .m_i      (m_q),
      .addend_o (addend)
   );

   always_comb begin
      a_ext = Signed_Mode ? {{3{A[WIDTH-1]}}, A} : {3'b000, A};
      b_ext = Signed_Mode ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};

      // Add the digit into H, then shift the whole {H,L,e} right by two with
      // sign replication so the next digit window lands in {L[1],L[0],e}.
      h_sum   = h_q + addend;
      shifted = RW'($signed({h_sum, l_q, e_q}) >>> 2);
      {h_d, l_d, e_d} = shifted;

      // After N shifts L holds the low W2 product bits; the rest comes from H.
      product_d = {h_d[WIDTH-3:0], l_d};
      last_iter = (cnt_q == CW'(N - 1));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         m_q       <= '0;
         h_q       <= '0;
         l_q       <= '0;
         e_q       <= 1'b0;
         product_q <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (Start_Sig) begin
                  m_q     <= a_ext;
                  h_q     <= '0;
                  l_q     <= b_ext;
                  e_q     <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_CALC;
               end
            end
            ST_CALC: begin
               h_q   <= h_d;
               l_q   <= l_d;
               e_q   <= e_d;
               cnt_q <= cnt_q + CW'(1);
               if (last_iter) begin
                  product_q <= product_d;
                  done_q    <= 1'b1;
                  state_q   <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign Busy     = busy_q;
   assign Done_Sig = done_q;
   assign Product  = product_q;
   // The port is one bit narrower than {H,L,e}; H's MSB is dropped from the view.
   assign SQ_p     = {h_q[HW-2:0], l_q, e_q};

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// tb/tb_booth_radix4_multiplier.sv - scoreboard bench for the radix-4 Booth multiplier, WIDTH=8
module tb_booth_radix4_multiplier;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           smode = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;
   logic [2*W+4:0] sq;

   int n_checks = 0;
   int n_fail   = 0;
   logic [2*W-1:0] exp_q[$];

   booth_radix4_multiplier #(.WIDTH(W)) dut (
      .CLK         (clk),
      .RST         (rst),
      .Start_Sig   (start),
      .Signed_Mode (smode),
      .A           (a),
      .B           (b),
      .Busy        (busy),
      .Done_Sig    (done),
      .Product     (product),
      .SQ_p        (sq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   function automatic logic [2*W-1:0] model(input logic sm, input logic [W-1:0] x, input logic [W-1:0] y);
      logic signed [31:0] sx, sy, p;
      sx = sm ? {{(32-W){x[W-1]}}, x} : {{(32-W){1'b0}}, x};
      sy = sm ? {{(32-W){y[W-1]}}, y} : {{(32-W){1'b0}}, y};
      p  = sx * sy;
      return p[2*W-1:0];
   endfunction

   // Monitor: every Done_Sig pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done product=%0h want=none", product);
         end else begin
            logic [2*W-1:0] e;
            e = exp_q.pop_front();
            if (product !== e) begin
               n_fail++;
               $display("FAIL product got=%0h want=%0h", product, e);
            end
         end
      end
   end

   task automatic wait_idle();
      int g;
      g = 0;
      @(negedge clk);
      while (busy !== 1'b0 && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g >= 50) check("wait_idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic run_op(input logic sm, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2*W-1:0] want);
      wait_idle();
      smode = sm;
      a     = x;
      b     = y;
      start = 1'b1;
      exp_q.push_back(want);
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_product", 32'(product), 32'd0);
      check("reset_sq", 32'(sq), 32'd0);

      // Directed vectors, hand-computed.
      run_op(1'b1, 8'h80, 8'h80, 16'h4000);
      run_op(1'b1, 8'h7F, 8'hFF, 16'hFF81);
      run_op(1'b1, 8'hFF, 8'hFF, 16'h0001);
      run_op(1'b0, 8'hFF, 8'hFF, 16'hFE01);
      run_op(1'b0, 8'h00, 8'hAB, 16'h0000);
      run_op(1'b1, 8'h80, 8'h7F, 16'hC080);
      run_op(1'b1, 8'h05, 8'hFD, 16'hFFF1);
      run_op(1'b0, 8'h80, 8'h02, 16'h0100);
      run_op(1'b0, 8'h7F, 8'h80, 16'h3F80);

      // Handshake: latency, Busy window, ignored second request.
      wait_idle();
      smode = 1'b1; a = 8'd3; b = 8'd5; start = 1'b1;
      exp_q.push_back(16'h000F);
      @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("hs_busy", 32'(busy), 32'(i <= 5));
         check("hs_done", 32'(done), 32'(i == 5));
         if (i == 0) start = 1'b0;
         if (i == 1) begin start = 1'b1; a = 8'd9; b = 8'd9; end
         if (i == 2) start = 1'b0;
      end

      // Back-to-back with Start_Sig held high.
      wait_idle();
      smode = 1'b1; a = 8'd3; b = 8'd5; start = 1'b1;
      exp_q.push_back(16'h000F);
      exp_q.push_back(16'hFFF2);
      @(posedge clk);
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (i == 0) begin a = 8'hFE; b = 8'h07; end
         check("b2b_done", 32'(done), 32'(i == 5 || i == 12));
         if (i == 6) check("b2b_idle_gap", 32'(busy), 32'd0);
         if (i == 7) begin
            check("b2b_reaccept", 32'(busy), 32'd1);
            start = 1'b0;
         end
      end

      // Reset mid-operation: no completion may follow.
      wait_idle();
      smode = 1'b0; a = 8'h55; b = 8'h33; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_product", 32'(product), 32'd0);
      check("abort_sq", 32'(sq), 32'd0);
      repeat (12) @(negedge clk);

      // Random operands against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         logic sm;
         logic [W-1:0] x, y;
         sm = 1'($urandom_range(0, 1));
         x  = W'($urandom);
         y  = W'($urandom);
         run_op(sm, x, y, model(sm, x, y));
      end

      begin
         int g;
         g = 0;
         while (exp_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
         end
         check("drain_outstanding", 32'(exp_q.size()), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
